// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: request/result bundle between the ID/EX latch and the mul/div unit.
interface ex_muldiv_if #(parameter int BITS_SIZE = 32);
    logic                 i_step;
    logic                 i_start;
    logic [2:0]           i_op;
    logic [BITS_SIZE-1:0] i_rs_data;
    logic [BITS_SIZE-1:0] i_rt_data;
    logic                 o_busy;
    logic                 o_done;
    logic [BITS_SIZE-1:0] o_hi;
    logic [BITS_SIZE-1:0] o_lo;
    modport master (output i_step, i_start, i_op, i_rs_data, i_rt_data, input o_busy, o_done, o_hi, o_lo);
    modport slave  (input i_step, i_start, i_op, i_rs_data, i_rt_data, output o_busy, o_done, o_hi, o_lo);
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative radix-2 multiply/divide unit owning the HI/LO registers.
module ex_muldiv #(
    parameter int BITS_SIZE = 32
) (
    input logic        i_clk,
    input logic        i_reset,
    ex_muldiv_if.slave bus
);
    localparam int B  = BITS_SIZE;
    localparam int CW = $clog2(B);
    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2*B-1:0]   acc;
    logic [B-1:0]     dvs;
    logic [B-1:0]     rs_lat;
    logic             neg_q;
    logic             neg_r;
    logic             is_div;
    logic [B-1:0]     hi;
    logic [B-1:0]     lo;
    logic             done;
    logic             sgn;
    logic [B-1:0]     rs_abs;
    logic [B-1:0]     rt_abs;
    logic [B:0]       mul_sum;
    logic [B:0]       div_diff;
    logic [2*B-1:0]   prod;
    logic [B-1:0]     fin_hi;
    logic [B-1:0]     fin_lo;
    always_comb begin
        sgn      = ~bus.i_op[0];
        rs_abs   = (sgn && bus.i_rs_data[B-1]) ? -bus.i_rs_data : bus.i_rs_data;
        rt_abs   = (sgn && bus.i_rt_data[B-1]) ? -bus.i_rt_data : bus.i_rt_data;
        mul_sum  = {1'b0, acc[2*B-1:B]} + {1'b0, acc[0] ? dvs : {B{1'b0}}};
        // Remainder shifted left needs one extra bit before the trial subtract
        div_diff = acc[2*B-1:B-1] - {1'b0, dvs};
        prod     = neg_q ? -acc : acc;
        fin_hi   = !is_div ? prod[2*B-1:B] : (dvs == '0) ? rs_lat : neg_r ? -acc[2*B-1:B] : acc[2*B-1:B];
        fin_lo   = !is_div ? prod[B-1:0] : (dvs == '0) ? {B{1'b1}} : neg_q ? -acc[B-1:0] : acc[B-1:0];
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            dvs    <= '0;
            rs_lat <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else if (bus.i_step) begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.i_start) begin
                    if (bus.i_op == 3'b100) hi <= bus.i_rs_data;
                    else if (bus.i_op == 3'b101) lo <= bus.i_rs_data;
                    else if (!bus.i_op[2]) begin
                        acc    <= {{B{1'b0}}, rs_abs};
                        dvs    <= rt_abs;
                        rs_lat <= bus.i_rs_data;
                        neg_q  <= sgn & (bus.i_rs_data[B-1] ^ bus.i_rt_data[B-1]);
                        neg_r  <= sgn & bus.i_op[1] & bus.i_rs_data[B-1];
                        is_div <= bus.i_op[1];
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc   <= !is_div ? {mul_sum, acc[B-1:1]} : div_diff[B] ? {acc[2*B-2:0], 1'b0} : {div_diff[B-1:0], acc[B-2:0], 1'b1};
                    cnt   <= cnt + CW'(1);
                    state <= (cnt == CW'(B-1)) ? FINISH : CALC;
                end
                FINISH: begin
                    hi    <= fin_hi;
                    lo    <= fin_lo;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.o_busy = (state != IDLE);
    assign bus.o_done = done;
    assign bus.o_hi   = hi;
    assign bus.o_lo   = lo;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and randomized checks of ex_muldiv against an arithmetic reference.
module tb_ex_muldiv;
    logic i_clk = 1'b0;
    logic i_reset;
    int   tests = 0;
    int   fails = 0;
    ex_muldiv_if #(.BITS_SIZE(32)) bus ();
    ex_muldiv #(.BITS_SIZE(32)) dut (.i_clk(i_clk), .i_reset(i_reset), .bus(bus));
    always #5 i_clk = ~i_clk;
    // Reference result {HI,LO} straight from 64-bit integer arithmetic
    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint sa, sb;
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return {32'b0, rs} * {32'b0, rt};
            3'd2: return (rt == 0) ? {rs, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            default: return (rt == 0) ? {rs, 32'hFFFF_FFFF} : {rs % rt, rs / rt};
        endcase
    endfunction
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt, input int stall_at, input int poke_at);
        logic [63:0] exp;
        logic [31:0] hs, ls;
        int n, t;
        exp = ref_model(op, rs, rt);
        bus.i_start = 1'b1; bus.i_op = op; bus.i_rs_data = rs; bus.i_rt_data = rt;
        @(negedge i_clk);
        bus.i_start = 1'b0; bus.i_rs_data = $urandom; bus.i_rt_data = $urandom;
        n = 0; t = 0;
        while (bus.o_busy === 1'b1 && n < 100) begin
            n++;
            if (n == stall_at) begin
                hs = bus.o_hi; ls = bus.o_lo;
                bus.i_step = 1'b0;
                repeat (10) @(negedge i_clk);
                t += 10;
                check("stall_busy", 64'(bus.o_busy), 64'd1);
                check("stall_hilo", {bus.o_hi, bus.o_lo}, {hs, ls});
                bus.i_step = 1'b1;
            end
            if (n == poke_at) begin
                bus.i_start = 1'b1; bus.i_op = 3'b100; bus.i_rs_data = 32'hDEAD_BEEF;
            end
            @(negedge i_clk);
            t++;
            bus.i_start = 1'b0;
        end
        check("busy_cycles", 64'(n), 64'd33);
        check("total_cycles", 64'(t), 64'(33 + ((stall_at > 0) ? 10 : 0)));
        check("done_pulse", 64'(bus.o_done), 64'd1);
        check("result", {bus.o_hi, bus.o_lo}, exp);
    endtask
    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        logic [31:0] hs, ls;
        hs = bus.o_hi; ls = bus.o_lo;
        bus.i_start = 1'b1; bus.i_op = op; bus.i_rs_data = v;
        @(negedge i_clk);
        bus.i_start = 1'b0;
        check("mt_busy", 64'(bus.o_busy), 64'd0);
        check("mt_hilo", {bus.o_hi, bus.o_lo}, (op == 3'b100) ? {v, ls} : (op == 3'b101) ? {hs, v} : {hs, ls});
    endtask
    initial begin
        logic [2:0]  rop;
        logic [31:0] rrs, rrt;
        i_reset = 1'b1;
        bus.i_step = 1'b1; bus.i_start = 1'b0; bus.i_op = '0; bus.i_rs_data = '0; bus.i_rt_data = '0;
        repeat (2) @(negedge i_clk);
        check("reset_state", {28'b0, bus.o_busy, bus.o_done, 2'b0, bus.o_hi, bus.o_lo}, 64'd0);
        i_reset = 1'b0;
        @(negedge i_clk);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("multu_max", {bus.o_hi, bus.o_lo}, 64'hFFFF_FFFE_0000_0001);
        @(negedge i_clk);
        check("done_width", 64'(bus.o_done), 64'd0);
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0, 0);
        check("mult_neg", {bus.o_hi, bus.o_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(3'd3, 32'd100, 32'd7, 0, 0);
        check("divu_100_7", {bus.o_hi, bus.o_lo}, {32'd2, 32'd14});
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div_neg", {bus.o_hi, bus.o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("div_ovf", {bus.o_hi, bus.o_lo}, 64'h0000_0000_8000_0000);
        run_op(3'd2, 32'd5, 32'd0, 0, 0);
        check("div_zero", {bus.o_hi, bus.o_lo}, {32'd5, 32'hFFFF_FFFF});
        run_op(3'd3, 32'd9, 32'd0, 0, 0);
        check("divu_zero", {bus.o_hi, bus.o_lo}, {32'd9, 32'hFFFF_FFFF});
        run_op(3'd2, 32'hFFFF_FFF6, 32'd0, 0, 0);
        run_op(3'd1, 32'd3, 32'd4, 12, 20);
        check("multu_stall", {bus.o_hi, bus.o_lo}, 64'd12);
        mt(3'b110, 32'h5555_5555);
        mt(3'b111, 32'hAAAA_AAAA);
        for (int i = 0; i < 14; i++) begin
            rop = 3'($urandom_range(0, 3));
            rrs = ($urandom_range(0, 3) == 0) ? 32'($signed(-$urandom_range(1, 1000))) : $urandom;
            case ($urandom_range(0, 3))
                0: rrt = 32'd0;
                1: rrt = 32'($urandom_range(1, 50));
                2: rrt = 32'($signed(-$urandom_range(1, 50)));
                default: rrt = $urandom;
            endcase
            run_op(rop, rrs, rrt, 0, 0);
        end
        bus.i_start = 1'b1; bus.i_op = 3'd1; bus.i_rs_data = $urandom; bus.i_rt_data = $urandom;
        @(negedge i_clk);
        bus.i_start = 1'b0;
        repeat (15) @(negedge i_clk);
        check("pre_reset_busy", 64'(bus.o_busy), 64'd1);
        #2 i_reset = 1'b1;
        #1 check("async_reset", {28'b0, bus.o_busy, bus.o_done, 2'b0, bus.o_hi, bus.o_lo}, 64'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        mt(3'b100, 32'h0000_1234);
        mt(3'b101, 32'h0000_ABCD);
        check("mt_final", {bus.o_hi, bus.o_lo}, {32'h1234, 32'hABCD});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Iterative multiply/divide unit for the EX stage. It consumes the operand and control outputs of the ID/EX latch and owns the architectural HI/LO registers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and raises o_busy so the hazard unit stalls the pipeline until the result is committed. All progress is gated by the debug step enable, so the unit freezes together with the pipeline.

Parameters:
BITS_SIZE  32  operand, HI and LO width; the iteration counter is clog2(BITS_SIZE) bits wide

Ports:
i_clk        in   1          clock; all state updates on rising edge
i_reset      in   1          asynchronous, active-high reset
i_step       in   1          step enable; when 0, all state holds
i_start      in   1          operation request from ID/EX; sampled only in IDLE
i_op         in   3          000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops
i_rs_data    in   BITS_SIZE  multiplicand / dividend / MTHI-MTLO source
i_rt_data    in   BITS_SIZE  multiplier / divisor
o_busy       out  1          high while state is CALC or FINISH; combinational decode of state
o_done       out  1          registered one-cycle pulse after HI/LO commit from a mul/div
o_hi         out  BITS_SIZE  HI register
o_lo         out  BITS_SIZE  LO register

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, counter=0, o_hi=0, o_lo=0, o_done=0, internal accumulators=0. Reset mid-operation aborts the operation; no partial HI/LO write.
- When i_step=0, nothing changes. This covers state, counter, accumulators and HI/LO. o_done also holds its value.
- States: IDLE, CALC, FINISH.
- IDLE, on i_step & i_start:
  - MTHI: o_hi<=i_rs_data at the same edge. State stays IDLE; o_busy never asserts.
  - MTLO: o_lo<=i_rs_data at the same edge. State stays IDLE; o_busy never asserts.
  - mul/div ops:
    - Latch |rs| and |rt|; absolute values apply to signed ops only.
    - Latch the result sign flags and the op.
    - Set counter=0 and go to CALC.
  - Ops 110/111: ignored.
- CALC: one radix-2 iteration per stepped edge, for BITS_SIZE iterations.
  - Multiply uses shift-add on a 2*BITS_SIZE accumulator.
  - Divide uses restoring division: remainder/quotient shift, then trial subtract.
  - On the edge that executes the iteration with counter=BITS_SIZE-1, go to FINISH.
- FINISH, on the next stepped edge:
  - Apply sign correction.
  - Write {HI,LO}; o_done<=1; go to IDLE.
- On any other stepped edge, o_done<=0.
- Latency: the start is accepted at edge E0. Iterations run on E1..E32. HI/LO commit at E33. o_busy is high for 33 stepped cycles. o_done is high in the cycle after E33.
- Result rules:
  - Multiply: {HI,LO} = 64-bit product.
    - MULT: two's-complement; the product is negated when the operand signs differ.
  - Divide: LO = quotient, HI = remainder.
    - Signed: the quotient is negated when signs differ; the remainder takes the dividend's sign (truncating division).
- Boundary cases:
  - Divide by zero, either signedness: HI=i_rs_data as latched, LO={BITS_SIZE{1'b1}}. Same latency; no exception.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
  - i_start while busy: ignored; the upstream hazard unit must hold the instruction while o_busy=1.
  - Operand inputs changing after E0: no effect.
  - Back-to-back requests: a new start is accepted in the cycle o_done is high. State is IDLE then.

Test Plan:
1. MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF, i_step=1 -> o_busy high exactly 33 cycles; HI=0xFFFFFFFE, LO=0x00000001 after E33; o_done 1-cycle pulse.
2. MULT rs=0xFFFFFFFD (-3), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIVU 100/7 -> LO=14, HI=2.
3. DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIV rs=5, rt=0 -> HI=5, LO=0xFFFFFFFF after 33 busy cycles. DIVU rs=9, rt=0 -> HI=9, LO=0xFFFFFFFF.
5. MULTU 3*4; drop i_step for 10 cycles at iteration 12 -> outputs and o_busy frozen; commit 10 cycles late, HI=0, LO=12. i_start with MTHI while busy -> HI unchanged.
6. Assert i_reset asynchronously at iteration 15 -> o_busy=0, HI=LO=0 immediately, o_done=0. Then MTHI 0x1234 -> HI=0x1234 after one edge, o_busy stays 0. MTLO 0xABCD -> LO=0xABCD.
